// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and line constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_tx_state_e;

  localparam logic        UART_IDLE_LVL        = 1'b1;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter with synchronous clear; tick marks the last
// cycle of a period, tick_next predicts tick for the following cycle.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned         CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || tick) count_d = '0;
  end

  assign tick      = (count_q == LAST_CNT);
  assign tick_next = (count_d == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a sync FIFO and serialises them as UART 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_enb,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  uart_tx_state_e    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic              rd_enb_q, rd_enb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, tick_next, clear_cnt;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_cnt),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      ST_IDLE:  if (tx_enable && !fifo_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d   = fifo_rd_data;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo_rd_data;
`endif
        state_d   = ST_START;
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    clear_cnt = (state_d != state_q);
    rd_enb_d  = (state_d == ST_POP);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_STOP) && tick_next;
    tx_d      = UART_IDLE_LVL;
    unique case (state_d)
      ST_START:  tx_d = ~UART_IDLE_LVL;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LVL;
      rd_enb_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rd_enb_q  <= rd_enb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd_enb = rd_enb_q;
  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: an 8-deep FIFO model feeds the DUT, a UART decoder
// on tx pops expected bytes from a scoreboard queue as frames complete.
module tb_fifo_uart_tx;

  localparam int unsigned C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = 11 * C;
`else
  localparam int unsigned FRAME_LEN = 10 * C;
`endif

  logic       clk = 1'b0;
  logic       rst, tx_enable, fifo_empty, fifo_full, fifo_rd_enb, tx, tx_busy, frame_done;
  logic [7:0] fifo_rd_data;

  logic       fifo_rst, wr_en, do_wr, do_rd, underrun, overrun;
  logic [7:0] wr_data;
  logic [7:0] mem [8];
  logic [2:0] wptr, rptr;
  logic [3:0] count;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_now = 0, mcyc = 0, frames_rx = 0, rd_pulses = 0, tx_low_cnt = 0;
  int unsigned prev_end = 0;
  int          prev_burst = 0, burst_id = 0;
  logic        in_frame = 1'b0, gap_check = 1'b0;
  logic [7:0]  rx_byte;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_enable    (tx_enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_enb  (fifo_rd_enb),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done)
  );

  // 8-deep synchronous FIFO, read data registered one cycle after rd_enb.
  assign fifo_empty = (count == 4'd0);
  assign fifo_full  = (count == 4'd8);
  assign do_rd      = fifo_rd_enb && !fifo_empty;
  assign do_wr      = wr_en && !fifo_full;

  always @(posedge clk) begin
    if (fifo_rst) begin
      wptr <= '0; rptr <= '0; count <= '0;
      underrun <= 1'b0; overrun <= 1'b0; fifo_rd_data <= '0;
    end else begin
      if (do_wr) begin mem[wptr] <= wr_data; wptr <= wptr + 3'd1; end
      if (do_rd) begin fifo_rd_data <= mem[rptr]; rptr <= rptr + 3'd1; end
      count    <= count + 4'(do_wr) - 4'(do_rd);
      underrun <= underrun | (fifo_rd_enb & fifo_empty);
      overrun  <= overrun | (wr_en & fifo_full);
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // UART decoder / scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    cyc_now++;
    if (fifo_rd_enb) rd_pulses++;
    if (!tx) tx_low_cnt++;
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (frame_done) check("spurious_frame_done", 32'(frame_done), 32'd0);
      if (!tx) begin
        in_frame = 1'b1;
        mcyc     = 1;
        rx_byte  = '0;
        if (gap_check && prev_burst == burst_id)
          check("frame_gap", cyc_now - prev_end - 1, 32'd3);
      end
    end else begin
      mcyc++;
      if (mcyc == 2) check("start_bit", 32'(tx), 32'd0);
      for (int j = 0; j < 8; j++)
        if (mcyc == C * (j + 1) + 2) rx_byte[j] = tx;
`ifdef FIFO_UART_TX_PARITY_EN
      if (mcyc == 9 * C + 2) check("parity_bit", 32'(tx), 32'(^rx_byte));
`endif
      if (mcyc == FRAME_LEN - 2) check("stop_bit", 32'(tx), 32'd1);
      if (mcyc < FRAME_LEN && frame_done) check("early_frame_done", 32'(frame_done), 32'd0);
      if (mcyc == FRAME_LEN) begin
        check("frame_done", 32'(frame_done), 32'd1);
        if (exp_q.size() == 0) check("unexpected_frame", 32'(rx_byte), 32'hFFFF_FFFF);
        else                   check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        frames_rx++;
        in_frame   = 1'b0;
        prev_end   = cyc_now;
        prev_burst = burst_id;
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    int unsigned guard = 0;
    while (fifo_full && guard < 2000) begin step(1); guard++; end
    if (fifo_full) check("fifo_full_timeout", 32'd1, 32'd0);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (frames_rx < target && n < budget) begin step(1); n++; end
    check("frames_received", frames_rx, target);
  endtask

  task automatic wait_tx_low(input int unsigned budget);
    int unsigned n = 0;
    while (tx && n < budget) begin step(1); n++; end
    check("tx_fall_seen", 32'(tx), 32'd0);
  endtask

  initial begin
    int unsigned p0, l0;
    logic [7:0] burst [12];
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    // Reset
    rst = 1'b1; fifo_rst = 1'b1; tx_enable = 1'b0; wr_en = 1'b0; wr_data = '0;
    step(2);
    rst = 1'b0; fifo_rst = 1'b0;
    step(1);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rd_enb", 32'(fifo_rd_enb), 32'd0);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_fifo_empty", 32'(fifo_empty), 32'd1);
    check("reset_underrun", 32'(underrun), 32'd0);

    // Single byte
    tx_enable = 1'b1;
    p0 = rd_pulses;
    push(8'hA5);
    wait_frames(1, 200);
    step(2);
    check("single_pops", rd_pulses - p0, 32'd1);
    check("single_empty_after", 32'(fifo_empty), 32'd1);

    // Burst of 12, paced by fifo_full
    p0 = rd_pulses;
    burst_id  = 1;
    gap_check = 1'b1;
    for (int i = 0; i < 12; i++) push(burst[i]);
    wait_frames(13, 12 * 60 + 100);
    gap_check = 1'b0;
    step(2);
    check("burst_pops", rd_pulses - p0, 32'd12);
    check("burst_empty_after", 32'(fifo_empty), 32'd1);
    check("burst_overrun", 32'(overrun), 32'd0);
    check("burst_underrun", 32'(underrun), 32'd0);

    // Empty hold
    p0 = rd_pulses;
    l0 = tx_low_cnt;
    step(100);
    check("hold_pops", rd_pulses - p0, 32'd0);
    check("hold_tx_low_cycles", tx_low_cnt - l0, 32'd0);
    check("hold_tx", 32'(tx), 32'd1);
    check("hold_underrun", 32'(underrun), 32'd0);

    // Gating mid-frame
    burst_id = 2;
    p0 = rd_pulses;
    push(8'h3C);
    push(8'h5A);
    wait_tx_low(50);
    step(12);
    check("gate_busy_mid", 32'(tx_busy), 32'd1);
    tx_enable = 1'b0;
    wait_frames(14, 100);
    step(60);
    check("gate_pops", rd_pulses - p0, 32'd1);
    check("gate_fifo_holds", 32'(fifo_empty), 32'd0);
    check("gate_frames", frames_rx, 32'd14);
    check("gate_idle", 32'(tx_busy), 32'd0);
    tx_enable = 1'b1;
    wait_frames(15, 200);
    step(2);
    check("gate_pops_after", rd_pulses - p0, 32'd2);
    check("gate_empty_after", 32'(fifo_empty), 32'd1);

    // Mid-frame reset during bit 3 of 0xF0
    burst_id = 3;
    p0 = rd_pulses;
    push(8'hF0);
    push(8'h96);
    wait_tx_low(50);
    step(17);
    rst = 1'b1;
    step(1);
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    exp_q.delete(0);
    rst = 1'b0;
    wait_frames(16, 200);
    step(2);
    check("rst_pops", rd_pulses - p0, 32'd2);
    check("rst_empty_after", 32'(fifo_empty), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("final_overrun", 32'(overrun), 32'd0);

    step(5);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
